robo_coletor_param: RTL

Parametrised successor of the maze-collector robot controller. It runs a left-wall-following FSM and issues one action per decision: forward, turn (90° counter-clockwise), or remove. The removal duration, settle spacing, move budget and start heading are configurable. It tracks its own heading, counts moves and removals, and flags exit, budget exhaustion and enclosure (stuck). It sits between the sensor front-end (head, left, under, barrier) and the drive/arm actuators.

---
 rtl/robo_coletor_param.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/robo_coletor_param.sv
// Left-wall-following maze collector controller with configurable
// removal time, settle spacing, move budget and start heading.
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset       asynchronous active-low reset, clears all state
//   head        wall directly ahead
//   left        wall on the left
//   under       robot standing on the exit/start marker
//   barrier     removable debris ahead
//   forward     one-cycle pulse: advance one cell
//   turn        one-cycle pulse: rotate 90 degrees counter-clockwise
//   remove      held REMOVE_CYCLES cycles: clear debris ahead
//   heading     current heading (N=00, S=01, L=10, O=11)
//   moves       forward pulses issued, saturating
//   removed     removals completed, saturating
//   done        exit reached or budget exhausted (sticky)
//   over_budget done caused by the move budget (sticky)
//   stuck       MAX_TURNS consecutive turns without advancing (sticky)

module robo_coletor_param #(
    parameter int         REMOVE_CYCLES = 3,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         MAX_TURNS     = 4,
    parameter int         MAX_MOVES     = 0,
    parameter int         CNT_W         = 16,
    parameter logic [1:0] START_DIR     = 2'b00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             head,
    input  logic             left,
    input  logic             under,
    input  logic             barrier,
    output logic             forward,
    output logic             turn,
    output logic             remove,
    output logic [1:0]       heading,
    output logic [CNT_W-1:0] moves,
    output logic [CNT_W-1:0] removed,
    output logic             done,
    output logic             over_budget,
    output logic             stuck
);

    localparam int CMAX = (REMOVE_CYCLES > SETTLE_CYCLES) ?
                          REMOVE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(MAX_TURNS + 1);

    localparam logic [CW-1:0]    REM_LAST  = CW'(REMOVE_CYCLES - 1);
    localparam logic [CW-1:0]    SET_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    TURN_LIM  = TW'(MAX_TURNS);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] MOVE_LIM  = CNT_W'(MAX_MOVES);
    localparam logic             BUDGET_ON = (MAX_MOVES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_SETTLE,
        S_REMOVE,
        S_DONE,
        S_STUCK
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             jl;
    logic             jl_n;
    logic [TW-1:0]    trun;
    logic [TW-1:0]    trun_n;
    logic [TW-1:0]    trun_inc;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             fwd_n;
    logic             turn_n;
    logic             rem_n;
    logic [1:0]       heading_n;
    logic [1:0]       heading_ccw;
    logic [CNT_W-1:0] moves_n;
    logic [CNT_W-1:0] moves_inc;
    logic [CNT_W-1:0] removed_n;
    logic [CNT_W-1:0] removed_inc;
    logic             take_turn;

    // Saturating increments: counters stick at all-ones.
    assign moves_inc   = (moves == CNT_SAT) ? moves : moves + 1'b1;
    assign removed_inc = (removed == CNT_SAT) ? removed : removed + 1'b1;
    assign trun_inc    = trun + 1'b1;

    // Counter-clockwise rotation: N -> O -> S -> L -> N.
    always_comb begin
        heading_ccw = 2'b00;
        case (heading)
            2'b00:   heading_ccw = 2'b11;
            2'b11:   heading_ccw = 2'b01;
            2'b01:   heading_ccw = 2'b10;
            default: heading_ccw = 2'b00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            jl      <= 1'b0;
            trun    <= '0;
            cnt     <= '0;
            forward <= 1'b0;
            turn    <= 1'b0;
            remove  <= 1'b0;
            heading <= START_DIR;
            moves   <= '0;
            removed <= '0;
        end else begin
            state   <= state_n;
            jl      <= jl_n;
            trun    <= trun_n;
            cnt     <= cnt_n;
            forward <= fwd_n;
            turn    <= turn_n;
            remove  <= rem_n;
            heading <= heading_n;
            moves   <= moves_n;
            removed <= removed_n;
        end
    end

    // Status flags follow the terminal state one cycle later. The budget
    // cause is recognised by the move count sitting at the limit: once
    // the limit is hit no further decision is ever taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done        <= 1'b0;
            over_budget <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            done        <= done | (state == S_DONE);
            over_budget <= over_budget |
                           ((state == S_DONE) && BUDGET_ON &&
                            (moves == MOVE_LIM));
            stuck       <= stuck | (state == S_STUCK);
        end
    end

    always_comb begin
        state_n   = state;
        jl_n      = jl;
        trun_n    = trun;
        cnt_n     = cnt;
        fwd_n     = 1'b0;
        turn_n    = 1'b0;
        rem_n     = 1'b0;
        heading_n = heading;
        moves_n   = moves;
        removed_n = removed;
        take_turn = 1'b0;

        case (state)
            S_IDLE: begin
                if (!under) begin
                    state_n = S_DECIDE;
                end
            end

            S_DECIDE: begin
                cnt_n = '0;
                if (under && (moves != '0)) begin
                    state_n = S_DONE;
                end else if (barrier) begin
                    rem_n   = 1'b1;
                    state_n = S_REMOVE;
                end else if (!left && !jl) begin
                    // Left opening: turn into it, then force one advance.
                    take_turn = 1'b1;
                    jl_n      = 1'b1;
                end else if (!head) begin
                    fwd_n   = 1'b1;
                    jl_n    = 1'b0;
                    trun_n  = '0;
                    moves_n = moves_inc;
                    if (BUDGET_ON && (moves_inc == MOVE_LIM)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_SETTLE;
                    end
                end else begin
                    take_turn = 1'b1;
                    jl_n      = 1'b0;
                end

                // The turn that exhausts the run is still pulsed.
                if (take_turn) begin
                    turn_n    = 1'b1;
                    heading_n = heading_ccw;
                    trun_n    = trun_inc;
                    if (trun_inc == TURN_LIM) begin
                        state_n = S_STUCK;
                    end else begin
                        state_n = S_SETTLE;
                    end
                end
            end

            S_REMOVE: begin
                if (cnt == REM_LAST) begin
                    removed_n = removed_inc;
                    cnt_n     = '0;
                    state_n   = S_SETTLE;
                end else begin
                    rem_n = 1'b1;
                    cnt_n = cnt + 1'b1;
                end
            end

            S_SETTLE: begin
                if (cnt == SET_LAST) begin
                    cnt_n   = '0;
                    state_n = S_DECIDE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_DONE: begin
                state_n = S_DONE;
            end

            S_STUCK: begin
                state_n = S_STUCK;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
